// File: rtl/dqpsk_symbol_slicer_pkg.sv
// Shared demodulator constants and elaboration helpers for the DQPSK symbol slicer.
package dqpsk_symbol_slicer_pkg;

  localparam logic [1:0] CODE_ZERO = 2'b00;
  localparam logic [1:0] CODE_ONE  = 2'b01;
  localparam logic [1:0] CODE_TWO  = 2'b10;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/dqpsk_symbol_slicer_iq_abs_thresh.sv
// One I/Q rail: registered saturating magnitude, then the threshold comparator and gated sign.
module iq_abs_thresh #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] x,
  input  logic [DW-2:0] thresh,
  output logic          act,
  output logic          sgn
);

  localparam logic [DW-2:0] ONE = 1;

  logic signed [DW-1:0] x_s;
  logic        [DW-2:0] abs_p0;
  logic                 neg_p0;

  // Most-negative input has no positive twin in DW bits; clamp it to full scale.
  function automatic logic [DW-2:0] sat_abs(input logic signed [DW-1:0] v);
    if (v[DW-1] && (v[DW-2:0] == '0)) return '1;
    if (v[DW-1]) return ~v[DW-2:0] + ONE;
    return v[DW-2:0];
  endfunction

  assign x_s = x;

  // stage p0: magnitude and sign capture
  always_ff @(posedge clk) begin
    if (en) begin
      abs_p0 <= sat_abs(x_s);
      neg_p0 <= x_s[DW-1];
    end
  end

  // Equality with the threshold is treated as noise.
  assign act = abs_p0 > thresh;
  assign sgn = act & neg_p0;

endmodule

// File: rtl/dqpsk_symbol_slicer.sv
// I/Q symbol decision: threshold slicing, quadrant-transition timing recovery, DPSK/coherent decode and lock.
module dqpsk_symbol_slicer
  import dqpsk_symbol_slicer_pkg::*;
#(
  parameter int DW           = 18,
  parameter int SPS          = 128,
  parameter int SAMPLE_PHASE = SPS / 2,
  parameter int LOCK_SYMS    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] i_in,
  input  logic [DW-1:0] q_in,
  input  logic [DW-2:0] thresh,
  input  logic          diff_en,
  output logic [1:0]    code_out,
  output logic          code_valid,
  output logic          sym_zero,
  output logic          lock
);

  localparam int PW = clog2(SPS);
  localparam int LW = clog2(LOCK_SYMS + 1);

  logic          act_i, sgn_i, act_q, sgn_q;
  logic          v1_p0, v2_p1;
  logic [1:0]    flag_p1;
  logic          zero_p1;
  logic [PW-1:0] phase_p2;
  logic [1:0]    flag_prev_p2, last_flag_p2;
  logic          t_p2;
  logic [LW-1:0] lock_cnt_p2;
  logic [1:0]    code_p2;
  logic          vld_p2, zero_p2;
  logic          transition, strike, t_n;

  iq_abs_thresh #(.DW(DW)) u_abs_i (
    .clk(clk), .en(s_valid), .x(i_in), .thresh(thresh), .act(act_i), .sgn(sgn_i)
  );

  iq_abs_thresh #(.DW(DW)) u_abs_q (
    .clk(clk), .en(s_valid), .x(q_in), .thresh(thresh), .act(act_q), .sgn(sgn_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_p0 <= 1'b0;
      v2_p1 <= 1'b0;
    end else begin
      v1_p0 <= s_valid;
      v2_p1 <= v1_p0;
    end
  end

  // stage p1: quadrant flag and no-signal detect
  always_ff @(posedge clk) begin
    if (v1_p0) begin
      flag_p1 <= {sgn_i, sgn_q};
      zero_p1 <= !act_i && !act_q;
    end
  end

  assign transition = flag_p1 != flag_prev_p2;
  assign strike     = v2_p1 && !transition && (phase_p2 == PW'(SAMPLE_PHASE));
  assign t_n        = t_p2 ^ (flag_p1 != last_flag_p2);

  // stage p2: timing recovery and registered decision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_p2     <= '0;
      flag_prev_p2 <= 2'b00;
      last_flag_p2 <= 2'b00;
      t_p2         <= 1'b0;
      lock_cnt_p2  <= '0;
      code_p2      <= CODE_ZERO;
      vld_p2       <= 1'b0;
      zero_p2      <= 1'b0;
    end else begin
      vld_p2 <= strike;
      if (v2_p1) begin
        flag_prev_p2 <= flag_p1;
        if (transition || (phase_p2 == PW'(SPS - 1))) phase_p2 <= '0;
        else                                           phase_p2 <= phase_p2 + PW'(1);
      end
      if (strike) begin
        if (zero_p1) begin
          code_p2     <= CODE_ZERO;
          zero_p2     <= 1'b1;
          lock_cnt_p2 <= '0;
        end else begin
          zero_p2      <= 1'b0;
          last_flag_p2 <= flag_p1;
          if (lock_cnt_p2 != LW'(LOCK_SYMS)) lock_cnt_p2 <= lock_cnt_p2 + LW'(1);
          if (diff_en) begin
            t_p2    <= t_n;
            code_p2 <= t_n ? CODE_ONE : CODE_TWO;
          end else begin
            code_p2 <= flag_p1;
          end
        end
      end
    end
  end

  assign code_out   = code_p2;
  assign code_valid = vld_p2;
  assign sym_zero   = zero_p2;
  assign lock       = lock_cnt_p2 == LW'(LOCK_SYMS);

endmodule

// File: tb/tb_dqpsk_symbol_slicer.sv
// Randomised scoreboard bench for dqpsk_symbol_slicer with a sample-level reference model.
module tb_dqpsk_symbol_slicer;

  localparam int DW  = 18;
  localparam int SPS = 128;
  localparam int SP  = 64;
  localparam int LS  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] i_in = '0;
  logic [DW-1:0] q_in = '0;
  logic [DW-2:0] thresh = '0;
  logic          diff_en = 1'b0;
  logic [1:0]    code_out;
  logic          code_valid, sym_zero, lock;

  dqpsk_symbol_slicer #(.DW(DW), .SPS(SPS), .SAMPLE_PHASE(SP), .LOCK_SYMS(LS)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .i_in(i_in), .q_in(q_in),
    .thresh(thresh), .diff_en(diff_en), .code_out(code_out),
    .code_valid(code_valid), .sym_zero(sym_zero), .lock(lock)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] code;
    logic       zero;
    logic       lock;
    int         stamp;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  int         m_phase, m_lock, m_thr;
  logic [1:0] m_fprev, m_last;
  logic       m_t, m_diff;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int mag(input int v);
    int a;
    a = (v < 0) ? -v : v;
    if (a > (1 << (DW - 1)) - 1) a = (1 << (DW - 1)) - 1;
    return a;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_fprev = 2'b00; m_last = 2'b00; m_t = 1'b0; m_lock = 0;
    sb.delete();
  endtask

  // Applies the decision rules to one accepted sample; queues a decision when it strikes.
  task automatic model_sample(input int i, input int q, input int stamp);
    logic ai, aq, zero, strike;
    logic [1:0] flag;
    exp_t e;
    ai = mag(i) > m_thr;
    aq = mag(q) > m_thr;
    flag = {ai && (i < 0), aq && (q < 0)};
    zero = !ai && !aq;
    strike = (flag == m_fprev) && (m_phase == SP);
    m_phase = (flag != m_fprev) ? 0 : (m_phase + 1) % SPS;
    m_fprev = flag;
    if (strike) begin
      e.stamp = stamp;
      if (zero) begin
        m_lock = 0;
        e.code = 2'b00;
        e.zero = 1'b1;
      end else begin
        if (m_lock < LS) m_lock++;
        e.zero = 1'b0;
        if (m_diff) begin
          if (flag != m_last) m_t = !m_t;
          e.code = m_t ? 2'b01 : 2'b10;
        end else begin
          e.code = flag;
        end
        m_last = flag;
      end
      e.lock = (m_lock == LS);
      sb.push_back(e);
    end
  endtask

  task automatic send(input int i, input int q);
    model_sample(i, q, cyc + 3);
    i_in = DW'(i);
    q_in = DW'(q);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_n(input int n, input int i, input int q);
    repeat (n) send(i, q);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input int thr, input logic d);
    idle(4);
    m_thr = thr;
    thresh = (DW - 1)'(thr);
    m_diff = d;
    diff_en = d;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_code_out"}, code_out, 0);
    chk({tag, "_code_valid"}, code_valid, 0);
    chk({tag, "_sym_zero"}, sym_zero, 0);
    chk({tag, "_lock"}, lock, 0);
  endtask

  task automatic do_reset();
    idle(1);
    rst = 1'b0;
    model_reset();
    idle(2);
    chk_zero_outputs("reset");
    rst = 1'b1;
    idle(1);
  endtask

  // Monitor: every code_valid pulse must match the oldest queued decision.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (code_valid === 1'b1) begin
        n_out++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_code_valid: got pulse expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("code_out", code_out, e.code);
          chk("sym_zero", sym_zero, e.zero);
          chk("lock", lock, e.lock);
          chk("latency", cyc, e.stamp);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, len, amp, si, sq, guard;
    m_thr = 1000; m_diff = 1'b1; thresh = 17'd1000; diff_en = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero_outputs("por");
    rst = 1'b1;
    idle(2);

    // constant (+,+): strikes at samples 64 and 192
    base = n_out;
    send_n(300, 5000, 5000);
    idle(5);
    chk("const_strike_count", n_out - base, 2);

    // alternating quadrants, then a repeated quadrant
    for (int s = 0; s < 6; s++) send_n(128, (s % 2) ? -5000 : 5000, 5000);
    send_n(256, -5000, 5000);
    idle(5);

    // below-threshold symbols, then a non-zero one
    for (int s = 0; s < 4; s++)
      send_n(128, ($urandom % 2) ? 999 : -999, ($urandom % 2) ? 999 : -999);
    send_n(200, 5000, -5000);
    idle(5);

    // most-negative input, coherent mode
    set_mode(1000, 1'b0);
    send(-131072, 0);
    chk("abs_i_saturated", dut.u_abs_i.abs_p0, 131071);
    send_n(200, -131072, 0);
    idle(5);

    // lock: 20 non-zero, one zero, 16 non-zero
    set_mode(1000, 1'b1);
    do_reset();
    send_n(2560, 5000, 5000);
    send_n(128, 500, 500);
    send_n(2048, 5000, 5000);
    idle(5);
    chk("lock_reacquired", lock, 1);

    // randomised symbols with gaps, mode/threshold changes and raw samples
    for (int s = 0; s < 30; s++) begin
      if ($urandom % 5 == 0) set_mode($urandom_range(500, 3000), 1'($urandom % 2));
      len = $urandom_range(90, 170);
      si  = ($urandom % 2) ? -1 : 1;
      sq  = ($urandom % 2) ? -1 : 1;
      amp = ($urandom % 6 == 0) ? $urandom_range(0, 400) : $urandom_range(3100, 130000);
      for (int n = 0; n < len; n++) begin
        if ($urandom % 8 == 0) idle($urandom_range(1, 3));
        if ($urandom % 40 == 0)
          send(int'($urandom) >>> 14, int'($urandom) >>> 14);
        else
          send(si * (amp + $urandom_range(0, 400) - 200), sq * (amp + $urandom_range(0, 400) - 200));
      end
    end
    idle(5);

    // asynchronous reset while a strike is in flight
    set_mode(1000, 1'b1);
    send(3000, -3000);
    guard = 0;
    while (m_phase != SP && guard < 200) begin
      send(3000, -3000);
      guard++;
    end
    chk("reach_strike_phase", m_phase, SP);
    send(3000, -3000);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk_zero_outputs("midreset");
    chk("midreset_phase", dut.phase_p2, 0);
    chk("midreset_t", dut.t_p2, 0);
    chk("midreset_flag_prev", dut.flag_prev_p2, 0);
    chk("midreset_last_flag", dut.last_flag_p2, 0);
    chk("midreset_lock_cnt", dut.lock_cnt_p2, 0);
    chk("midreset_v1", dut.v1_p0, 0);
    chk("midreset_v2", dut.v2_p1, 0);
    idle(2);
    rst = 1'b1;
    base = n_out;
    send_n(150, 3000, -3000);
    idle(5);
    chk("post_reset_strike_count", n_out - base, 1);

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dqpsk_symbol_slicer.md
# dqpsk_symbol_slicer

Parametrised I/Q symbol decision block for the baseband demodulator. It sits after the matched filter and derotator. It takes one complex sample per `s_valid` strobe and takes magnitudes with a programmable noise threshold. It recovers symbol timing from quadrant transitions, then emits one 2-bit decision per symbol in either differential (DPSK) or coherent (quadrant) mode, with a zero/no-signal flag and a lock indicator. It generalises the single-rate fixed-threshold slicer to arbitrary width, oversampling ratio, sample phase and runtime mode.

## Interface
Parameters:
- `DW`, 18: signed sample width of `i_in`/`q_in`.
- `SPS`, 128: samples per symbol; any value ≥ 4.
- `SAMPLE_PHASE`, `SPS/2`: phase-counter value at which a symbol is decided; must satisfy 0 < SAMPLE_PHASE < SPS.
- `LOCK_SYMS`, 16: consecutive non-zero decisions required to assert `lock`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `s_valid`, in, 1: sample strobe, one-cycle pulse per input sample.
- `i_in`, in, DW: in-phase sample, two's complement.
- `q_in`, in, DW: quadrature sample, two's complement.
- `thresh`, in, DW-1: unsigned magnitude threshold; quasi-static.
- `diff_en`, in, 1: 1 = differential decode, 0 = coherent quadrant.
- `code_out`, out, 2: symbol decision.
- `code_valid`, out, 1: one-cycle pulse qualifying `code_out`/`sym_zero`.
- `sym_zero`, out, 1: decision was a below-threshold symbol.
- `lock`, out, 1: LOCK_SYMS consecutive non-zero decisions seen.

## Operation
- Stage 1 (on `s_valid`):
  - `abs_i`/`abs_q` = |x| as DW-1 bits.
  - The most-negative input saturates to 2^(DW-1)-1.
  - Valid tag `v1` = `s_valid`.
- Stage 2 (on `v1`):
  - `act_x` = `abs_x > thresh`.
  - `sgn_x` = `act_x ? sign(x) : 0`.
  - `flag` = {`sgn_i`, `sgn_q`}.
  - `zero` = !`act_i` && !`act_q`; note `abs == thresh` counts as inactive.
  - Valid tag `v2`.
- Timing recovery (on `v2`):
  - `flag_prev` is updated to `flag`.
  - Transition = `flag != flag_prev` → `phase` <= 0.
  - Otherwise `phase` <= (`phase == SPS-1`) ? 0 : `phase+1`.
  - `strike` = `v2` && no transition && `phase == SAMPLE_PHASE`.
- Decision (registered on `strike`):
  - Zero symbol (`zero`=1):
    - `code_out`=00, `sym_zero`=1.
    - `last_flag`, `T` and `lock` progress are untouched, except that the lock count clears.
  - Non-zero symbol, `diff_en`=1:
    - `chg` = `flag != last_flag`.
    - `T_n` = `T ^ chg`; `T` <= `T_n`; `last_flag` <= `flag`.
    - `code_out` = `T_n` ? 01 : 10.
  - Non-zero symbol, `diff_en`=0:
    - `code_out` = `flag`; `last_flag` <= `flag`; `T` unchanged.
  - Non-zero symbol, either mode: `sym_zero`=0.
- Lock counter (saturating at LOCK_SYMS):
  - Increments on each non-zero strike and clears on a zero strike.
  - `lock` = count == LOCK_SYMS.
- `code_out`/`sym_zero` hold their value between strikes.

## Timing
- Latency: `s_valid` at edge k → `abs` at k+1, `flag`/`zero` at k+2, `code_valid` high during cycle k+3 (pulse of exactly 1 clk).
- At most one `code_valid` per SPS samples in steady state. A transition restarts the count, so the next strike falls SAMPLE_PHASE samples after it.
- `s_valid` may be high on consecutive clocks (full-rate); the pipeline accepts one sample per clock.
- Gaps in `s_valid` freeze `phase`. Stage registers hold, but their valid tags drop.
- Reset (async assert, any time including mid-pipeline):
  - Outputs: `code_out`=00, `code_valid`=0, `sym_zero`=0, `lock`=0.
  - Internal: `phase`=0, `T`=0, `flag_prev`=`last_flag`=00, lock count 0, `v1`=`v2`=0.
- First post-reset sample is compared against `flag_prev`=00.
- Changing `diff_en` mid-stream takes effect at the next strike, and `T` is preserved.

## Structure
- Shared demod package holds:
  - the code constants `CODE_ZERO`=00, `CODE_ONE`=01, `CODE_TWO`=10;
  - the function `clog2` used for the `phase` width, clog2(SPS).
- One natural sub-module, `iq_abs_thresh`. It is instantiated per rail and contains the saturating abs and the `act`/`sgn` logic, as stage 1 plus the comparator.
- Expected size 150–250 lines.

## Test plan
- Constant I=+5000, Q=+5000, thresh=1000, 300 full-rate samples, diff_en=1:
  - first `code_valid` at k+3 after sample 0+64 (SAMPLE_PHASE=64);
  - then every 128 samples, `code_out`=10, `sym_zero`=0.
- Quadrant change (+,+)→(−,+) every 128 samples, diff_en=1:
  - `code_out` alternates 01,10,01… on each changed symbol;
  - same quadrant repeated yields the held-T code.
- I=Q=±999 with thresh=1000: `code_valid` pulses with `code_out`=00 and `sym_zero`=1. `lock` stays 0, and `T` is unchanged on the next non-zero symbol.
- I=−2^17 (most negative), Q=0, diff_en=0:
  - `abs_i`=131071;
  - `code_out`=10 (sgn_i=1, sgn_q=0).
- 20 non-zero symbols, then one zero, then 16 non-zero:
  - `lock` rises after the 16th, drops on the zero;
  - re-rises after 16 more.
- Assert `rst` low during cycle k+2 of a strike: no `code_valid`; all outputs and state reads zero; the next strike follows the post-reset timing.
